sign_contr_multi: RTL



---
 rtl/sign_contr_multi.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sign_contr_multi.sv
// sign_contr_multi: NUM_APP-approach signal controller; main road rests on
// green, side roads are served on latched demand in round-robin order.
module sign_contr_multi #(
  parameter int NUM_APP     = 2,
  parameter int TW          = 8,
  parameter int MIN_GREEN   = 8,
  parameter int MAX_GREEN   = 32,
  parameter int YEL_TIME    = 3,
  parameter int ALLRED_TIME = 2
) (
  input  logic                 CLOCK,
  input  logic                 CLEAR,
  input  logic [NUM_APP-1:0]   CAR_REQ,
  output logic [2*NUM_APP-1:0] SIG,
  output logic [2:0]           ACTIVE,
  output logic [NUM_APP-1:0]   PENDING
);

  typedef enum logic [2:0] {
    MAIN_GREEN,
    MAIN_YEL,
    AR_TO_SIDE,
    SIDE_GREEN,
    SIDE_YEL,
    AR_TO_MAIN
  } state_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam logic [TW:0] T_MIN = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0] T_MAX = (TW+1)'(MAX_GREEN);
  localparam logic [TW:0] T_YEL = (TW+1)'(YEL_TIME);
  localparam logic [TW:0] T_AR  = (TW+1)'(ALLRED_TIME);
  localparam logic [TW:0] T_ONE = (TW+1)'(1);

  localparam logic [TW-1:0] T_SAT = '1;
  localparam logic [TW-1:0] T_INC = (TW)'(1);

  localparam logic [NUM_APP-1:0] SIDE_MASK = ~((NUM_APP)'(1));
  localparam logic [2*NUM_APP-1:0] SIG_RST = (2*NUM_APP)'(GREEN);
  localparam logic [2:0] LAST_APP = 3'(NUM_APP-1);

  state_t              state;
  state_t              state_n;
  logic [TW-1:0]       timer;
  logic [TW:0]         t1;
  logic [2:0]          rr_ptr;
  logic [2:0]          rr_n;
  logic [2:0]          sel_n;
  logic [2:0]          pick;
  logic                found;
  logic                req_sel;
  logic [NUM_APP-1:0]  pend_n;
  logic [2*NUM_APP-1:0] sig_n;

  // Round-robin pick: first pending side road at or after rr_ptr, wrapping to 1.
  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 0; k < NUM_APP-1; k++) begin
      for (int i = 1; i < NUM_APP; i++) begin
        if (!found && PENDING[i] &&
            ((int'(rr_ptr) + k == i) ||
             (int'(rr_ptr) + k - (NUM_APP-1) == i))) begin
          found = 1'b1;
          pick  = 3'(i);
        end
      end
    end
  end

  always_comb begin
    req_sel = 1'b0;
    for (int i = 1; i < NUM_APP; i++) begin
      if (ACTIVE == 3'(i)) req_sel = CAR_REQ[i];
    end
  end

  always_comb begin
    t1      = {1'b0, timer} + T_ONE;
    state_n = state;
    sel_n   = ACTIVE;
    rr_n    = rr_ptr;
    unique case (state)
      MAIN_GREEN: begin
        if (t1 >= T_MIN && found) begin
          state_n = MAIN_YEL;
          sel_n   = pick;
          rr_n    = (pick == LAST_APP) ? 3'd1 : pick + 3'd1;
        end
      end
      MAIN_YEL: begin
        if (t1 == T_YEL) state_n = AR_TO_SIDE;
      end
      AR_TO_SIDE: begin
        if (t1 == T_AR) state_n = SIDE_GREEN;
      end
      SIDE_GREEN: begin
        if ((t1 >= T_MIN && !req_sel) || t1 == T_MAX) state_n = SIDE_YEL;
      end
      SIDE_YEL: begin
        if (t1 == T_YEL) state_n = AR_TO_MAIN;
      end
      AR_TO_MAIN: begin
        if (t1 == T_AR) begin
          state_n = MAIN_GREEN;
          sel_n   = 3'd0;
        end
      end
      default: state_n = MAIN_GREEN;
    endcase
  end

  // The served road's request is held clear on green entry and throughout green.
  always_comb begin
    pend_n = (PENDING | CAR_REQ) & SIDE_MASK;
    for (int i = 1; i < NUM_APP; i++) begin
      if (ACTIVE == 3'(i) &&
          (state == SIDE_GREEN || state_n == SIDE_GREEN)) begin
        pend_n[i] = 1'b0;
      end
    end
  end

  always_comb begin
    sig_n = {NUM_APP{RED}};
    unique case (state_n)
      MAIN_GREEN: sig_n[1:0] = GREEN;
      MAIN_YEL:   sig_n[1:0] = YELLOW;
      SIDE_GREEN, SIDE_YEL: begin
        for (int i = 1; i < NUM_APP; i++) begin
          if (sel_n == 3'(i)) begin
            sig_n[2*i +: 2] = (state_n == SIDE_GREEN) ? GREEN : YELLOW;
          end
        end
      end
      default: sig_n = {NUM_APP{RED}};
    endcase
  end

  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      state   <= MAIN_GREEN;
      timer   <= '0;
      PENDING <= '0;
      ACTIVE  <= 3'd0;
      rr_ptr  <= 3'd1;
      SIG     <= SIG_RST;
    end else begin
      state   <= state_n;
      PENDING <= pend_n;
      ACTIVE  <= sel_n;
      rr_ptr  <= rr_n;
      SIG     <= sig_n;
      if (state_n != state) timer <= '0;
      else if (timer != T_SAT) timer <= timer + T_INC;
    end
  end

endmodule
